// File: rtl/rv_mc_core_if.sv
// Command/status bundle between a host sequencer and rv_mc_core.
interface rv_mc_core_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    logic [31:0]           command;
    logic                  run;
    logic                  ready;
    logic                  done;
    logic                  illegal;
    logic [NREGS*XLEN-1:0] reg_values;
    logic [XLEN-1:0]       pc;

    modport master (output command, run, input ready, done, illegal, reg_values, pc);
    modport slave  (input command, run, output ready, done, illegal, reg_values, pc);
endinterface

// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I/RV64I integer core: one instruction per four cycles, no memory ops.
// state | meaning: IDLE wait for run | DECODE read rs1/rs2 | EXEC compute result, target, legality | WB commit, pulse done
module rv_mc_core #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         reset,
    rv_mc_core_if.slave bus
);
    localparam int         SH = $clog2(XLEN);
    localparam int         RW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] OPC_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t          state;
    logic [31:0]     cmd;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] pc, op_a, op_b, res_q, npc_q;
    logic            wen_q, bad_q, done, illegal;

    logic [6:0]      opc, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;

    assign opc   = cmd[6:0];
    assign rd    = cmd[11:7];
    assign f3    = cmd[14:12];
    assign rs1   = cmd[19:15];
    assign rs2   = cmd[24:20];
    assign f7    = cmd[31:25];
    assign imm_i = XLEN'($signed(cmd[31:20]));
    assign imm_u = XLEN'($signed({cmd[31:12], 12'b0}));
    assign imm_b = XLEN'($signed({cmd[31], cmd[7], cmd[30:25], cmd[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({cmd[31], cmd[19:12], cmd[20], cmd[30:21], 1'b0}));

    logic [XLEN-1:0] b, res, npc, pc4, sra;
    logic [31:0]     w, sraw;
    logic            wen, bad, taken, jump, legal, use_rs1, use_rs2, use_rd, shl_ok, shr_ok;

    always_comb begin
        pc4     = pc + XLEN'(4);
        b       = (opc == OPC_OP || opc == OPC_OP32) ? op_b : imm_i;
        sra     = $signed(op_a) >>> b[SH-1:0];
        sraw    = $signed(op_a[31:0]) >>> b[4:0];
        shl_ok  = (cmd[31:20] >> SH) == 12'd0;
        shr_ok  = shl_ok || ((cmd[31:20] >> SH) == (12'h400 >> SH));
        res     = '0;
        npc     = pc4;
        w       = '0;
        taken   = 1'b0;
        jump    = 1'b0;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        case (opc)
            OPC_OP, OPC_IMM: begin
                use_rs1 = 1'b1;
                use_rs2 = (opc == OPC_OP);
                case (f3)
                    3'b000:  res = (opc == OPC_OP && cmd[30]) ? op_a - b : op_a + b;
                    3'b001:  res = op_a << b[SH-1:0];
                    3'b010:  res = XLEN'($signed(op_a) < $signed(b));
                    3'b011:  res = XLEN'(op_a < b);
                    3'b100:  res = op_a ^ b;
                    3'b101:  res = cmd[30] ? sra : op_a >> b[SH-1:0];
                    3'b110:  res = op_a | b;
                    default: res = op_a & b;
                endcase
                if (opc == OPC_OP)
                    legal = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                else
                    legal = (f3 == 3'b001) ? shl_ok : (f3 == 3'b101) ? shr_ok : 1'b1;
            end
            OPC_OP32, OPC_IMM32: begin
                use_rs1 = 1'b1;
                use_rs2 = (opc == OPC_OP32);
                case (f3)
                    3'b000:  w = (opc == OPC_OP32 && cmd[30]) ? op_a[31:0] - b[31:0] : op_a[31:0] + b[31:0];
                    3'b001:  w = op_a[31:0] << b[4:0];
                    default: w = cmd[30] ? sraw : op_a[31:0] >> b[4:0];
                endcase
                res   = XLEN'($signed(w));
                legal = (XLEN == 64) && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) &&
                        ((opc == OPC_IMM32 && f3 == 3'b000) || f7 == 7'd0 ||
                         (f7 == 7'b0100000 && f3 != 3'b001));
            end
            OPC_LUI: begin
                res   = imm_u;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                res   = pc + imm_u;
                legal = 1'b1;
            end
            OPC_JAL: begin
                res   = pc4;
                npc   = pc + imm_j;
                jump  = 1'b1;
                legal = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                res     = pc4;
                npc     = (op_a + imm_i) & ~XLEN'(1);
                jump    = 1'b1;
                legal   = (f3 == 3'b000);
            end
            OPC_BR: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b0;
                case (f3)
                    3'b000:  taken = (op_a == op_b);
                    3'b001:  taken = (op_a != op_b);
                    3'b100:  taken = ($signed(op_a) < $signed(op_b));
                    3'b101:  taken = ($signed(op_a) >= $signed(op_b));
                    3'b110:  taken = (op_a < op_b);
                    default: taken = (op_a >= op_b);
                endcase
                if (taken) npc = pc + imm_b;
                jump  = taken;
                legal = (f3 != 3'b010) && (f3 != 3'b011);
            end
            default: legal = 1'b0;
        endcase
        // Out-of-range indices only matter for fields the format actually uses.
        bad = !legal || (jump && npc[1]) ||
              (use_rs1 && {1'b0, rs1} >= NR) ||
              (use_rs2 && {1'b0, rs2} >= NR) ||
              (use_rd  && {1'b0, rd}  >= NR);
        wen = !bad && use_rd && (rd != 5'd0);
        if (bad) npc = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cmd     <= '0;
            pc      <= RESET_PC;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            npc_q   <= RESET_PC;
            wen_q   <= 1'b0;
            bad_q   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        cmd   <= bus.command;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    op_a  <= regs[rs1[RW-1:0]];
                    op_b  <= regs[rs2[RW-1:0]];
                    state <= EXEC;
                end
                EXEC: begin
                    res_q <= res;
                    npc_q <= npc;
                    wen_q <= wen;
                    bad_q <= bad;
                    state <= WB;
                end
                default: begin
                    if (wen_q) regs[rd[RW-1:0]] <= res_q;
                    pc      <= npc_q;
                    done    <= 1'b1;
                    illegal <= bad_q;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.done    = done;
    assign bus.illegal = illegal;
    assign bus.pc      = pc;

    for (genvar i = 0; i < NREGS; i++) begin : g_rv
        assign bus.reg_values[i*XLEN +: XLEN] = regs[i];
    end
endmodule

// File: tb/tb_rv_mc_core.sv
// Directed bench: three cores (RV32/32 regs, RV32/16 regs with RESET_PC 0x100, RV64) run one command stream in lockstep.
module tb_rv_mc_core;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPIW = 7'b0011011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] command = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        ill_a, ill_b, ill_c;

    always #5 clk = ~clk;

    rv_mc_core_if #(.XLEN(32), .NREGS(32)) if_a ();
    rv_mc_core_if #(.XLEN(32), .NREGS(16)) if_b ();
    rv_mc_core_if #(.XLEN(64), .NREGS(32)) if_c ();

    assign if_a.command = command;
    assign if_a.run     = run;
    assign if_b.command = command;
    assign if_b.run     = run;
    assign if_c.command = command;
    assign if_c.run     = run;

    rv_mc_core #(.XLEN(32), .NREGS(32)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    rv_mc_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) u_b (.clk(clk), .reset(reset), .bus(if_b));
    rv_mc_core #(.XLEN(64), .NREGS(32)) u_c (.clk(clk), .reset(reset), .bus(if_c));

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] xa(input int i);
        return if_a.reg_values[i*32 +: 32];
    endfunction
    function automatic logic [31:0] xb(input int i);
        return if_b.reg_values[i*32 +: 32];
    endfunction
    function automatic logic [63:0] xc(input int i);
        return if_c.reg_values[i*64 +: 64];
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        logic [11:0] im;
        im = imm[11:0];
        return {im, 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP};
    endfunction
    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = imm[12:0];
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [20:0] im;
        im = imm[20:0];
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction

    // Issue one command, then require done exactly on the third edge after capture.
    task automatic exec(input logic [31:0] c, input string tag);
        int k;
        @(negedge clk);
        command = c;
        run     = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        k = 0;
        ill_a = 1'b0;
        ill_b = 1'b0;
        ill_c = 1'b0;
        for (int n = 1; n <= 8 && k == 0; n++) begin
            @(posedge clk);
            #1;
            if (if_a.done) begin
                k = n;
                ill_a = if_a.illegal;
                ill_b = if_b.illegal;
                ill_c = if_c.illegal;
            end
        end
        chk_val({tag, "_latency"}, 64'(k), 64'd3);
    endtask

    initial begin
        logic [31:0] seq [3];
        int          done_cyc [3];
        int          idx, ndone, cyc;
        logic        seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_val("rst_ready", if_a.ready, 1'b1);
        chk_val("rst_done", if_a.done, 1'b0);
        chk_val("rst_illegal", if_a.illegal, 1'b0);
        chk_val("rst_pc_a", if_a.pc, 32'h0);
        chk_val("rst_pc_b", if_b.pc, 32'h100);

        exec(enc_i(10, 0, 0, 1, OPI), "addi_x1");
        exec(enc_i(-4, 0, 0, 2, OPI), "addi_x2");
        exec(enc_r(0, 2, 1, 0, 3), "add_x3");
        exec(enc_r(32, 2, 1, 0, 4), "sub_x4");
        chk_val("x1", xa(1), 32'd10);
        chk_val("x2", xa(2), 32'hFFFF_FFFC);
        chk_val("x3", xa(3), 32'd6);
        chk_val("x4", xa(4), 32'd14);
        chk_val("pc_16", if_a.pc, 32'd16);
        chk_val("c_x2_sext", xc(2), 64'hFFFF_FFFF_FFFF_FFFC);

        exec(enc_i(2, 0, 0, 7, OPI), "addi_x7");
        exec(enc_r(0, 7, 2, 1, 10), "sll");
        exec(enc_r(0, 7, 2, 5, 11), "srl");
        exec(enc_r(32, 7, 2, 5, 12), "sra");
        exec(enc_r(0, 2, 0, 3, 6), "sltu_x6");
        exec(enc_r(0, 1, 2, 2, 5), "slt_x5");
        exec(enc_r(0, 1, 2, 3, 8), "sltu_x8");
        chk_val("sll_x10", xa(10), 32'hFFFF_FFF0);
        chk_val("srl_x11", xa(11), 32'h3FFF_FFFF);
        chk_val("sra_x12", xa(12), 32'hFFFF_FFFF);
        chk_val("sltu_x6", xa(6), 32'd1);
        chk_val("slt_x5", xa(5), 32'd1);
        chk_val("sltu_x8", xa(8), 32'd0);
        chk_val("c_srl_x11", xc(11), 64'h3FFF_FFFF_FFFF_FFFF);
        chk_val("pc_44", if_a.pc, 32'd44);

        // Abort ADDI x1,x0,7 with reset held across its EXEC edge.
        @(negedge clk);
        command = enc_i(7, 0, 0, 1, OPI);
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_val("abort_ready", if_a.ready, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (if_a.done) seen = 1'b1;
        end
        chk_val("abort_no_done", seen, 1'b0);
        chk_val("abort_x1", xa(1), 32'd0);
        chk_val("abort_pc_a", if_a.pc, 32'd0);
        chk_val("abort_pc_b", if_b.pc, 32'h100);

        exec(enc_b(0, 0, 0, 8), "beq_taken");
        chk_val("beq_pc", if_a.pc, 32'd8);
        exec(enc_b(1, 0, 0, 8), "bne_not_taken");
        chk_val("bne_pc", if_a.pc, 32'd12);
        exec(enc_j(1, -12), "jal");
        chk_val("jal_x1", xa(1), 32'd16);
        chk_val("jal_pc", if_a.pc, 32'd0);
        chk_val("jal_illegal", ill_a, 1'b0);
        chk_val("b_jal_x1", xb(1), 32'h110);
        chk_val("b_jal_pc", if_b.pc, 32'h100);
        exec(enc_b(0, 0, 0, 6), "beq_misaligned");
        chk_val("misalign_illegal", ill_a, 1'b1);
        chk_val("misalign_pc", if_a.pc, 32'd0);

        exec(enc_i(5, 0, 0, 0, OPI), "addi_x0");
        chk_val("x0_zero", xa(0), 32'd0);
        chk_val("x0_pc", if_a.pc, 32'd4);
        exec(enc_i(1, 0, 0, 20, OPI), "addi_x20");
        chk_val("a_x20", xa(20), 32'd1);
        chk_val("a_x20_legal", ill_a, 1'b0);
        chk_val("b_x20_illegal", ill_b, 1'b1);
        chk_val("b_x4_untouched", xb(4), 32'd0);
        chk_val("b_x1_untouched", xb(1), 32'h110);
        chk_val("b_pc_held", if_b.pc, 32'h104);

        // Back-to-back with junk on command while busy.
        seq[0] = enc_i(1, 0, 0, 5, OPI);
        seq[1] = enc_i(2, 5, 0, 6, OPI);
        seq[2] = enc_r(0, 6, 5, 0, 7);
        done_cyc[0] = 0;
        done_cyc[1] = 0;
        done_cyc[2] = 0;
        @(posedge clk);
        #1;
        idx = 0;
        ndone = 0;
        cyc = 0;
        while (ndone < 3 && cyc < 40) begin
            @(negedge clk);
            if (if_a.done) begin
                done_cyc[ndone] = cyc;
                ndone++;
            end
            if (if_a.ready) begin
                if (idx < 3) begin
                    command = seq[idx];
                    run = 1'b1;
                    idx++;
                end else begin
                    run = 1'b0;
                end
            end else begin
                command = enc_i(99, 0, 0, 5, OPI);
                run = 1'b1;
            end
            cyc++;
        end
        run = 1'b0;
        chk_val("b2b_count", 64'(ndone), 64'd3);
        chk_val("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd4);
        chk_val("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd4);
        chk_val("b2b_x5", xa(5), 32'd1);
        chk_val("b2b_x6", xa(6), 32'd3);
        chk_val("b2b_x7", xa(7), 32'd4);
        chk_val("b2b_pc", if_a.pc, 32'd20);

        exec(enc_i(-1, 0, 0, 1, OPIW), "addiw");
        chk_val("c_addiw_x1", xc(1), 64'hFFFF_FFFF_FFFF_FFFF);
        chk_val("a_addiw_illegal", ill_a, 1'b1);
        chk_val("a_addiw_x1_kept", xa(1), 32'd16);
        exec(enc_i(32, 1, 1, 3, OPI), "slli32");
        chk_val("c_slli32_x3", xc(3), 64'hFFFF_FFFF_0000_0000);
        chk_val("c_slli32_legal", ill_c, 1'b0);
        chk_val("a_slli32_illegal", ill_a, 1'b1);
        chk_val("a_pc_final", if_a.pc, 32'd20);
        chk_val("c_pc_final", if_c.pc, 64'd28);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rv_mc_core.md
RV_MC_CORE -- requirements
Module: rv_mc_core

Interface
REQ-001 Parameter XLEN, default 32, sets the datapath/register width; legal values are 32 and 64.
REQ-002 Parameter NREGS, default 32, sets the architectural register count; legal values are 16 and 32.
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  is a synchronous, active-high reset.
REQ-006 command  input  32  carries the RV instruction word, sampled only on a capture edge.
REQ-007 run  input  1  is the command-valid strobe.
REQ-008 ready  output  1  is high while the core is idle and able to capture.
REQ-009 done  output  1  is a one-cycle pulse marking instruction retirement.
REQ-010 illegal  output  1  is a one-cycle pulse, coincident with done, flagging a rejected instruction.
REQ-011 reg_values  output  NREGS*XLEN  exposes the register file flattened, with x[i] at bits [i*XLEN +: XLEN].
REQ-012 pc  output  XLEN  is the current program counter.

Function
REQ-013 FSM states are IDLE, DECODE, EXEC and WB; ready = (state == IDLE).
REQ-014 Capture edge: a rising edge with state = IDLE and run = 1 latches command and moves to DECODE.
REQ-015 Sequencing: DECODE -> EXEC -> WB advance unconditionally, one edge each; on the WB edge the result is written, pc is updated, state returns to IDLE and done is registered high for exactly one cycle.
REQ-016 Latency: done is high in the cycle following the third edge after capture; maximum throughput is one instruction per 4 cycles.
REQ-017 Back-to-back operation: run held high captures the next command on the edge that ends the done cycle.
REQ-018 Busy behaviour: run and command are ignored outside IDLE; the latched command is stable through WB.
REQ-019 Supported opcodes: OP, OP_IMM, LUI, AUIPC, JAL, JALR and BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-020 When XLEN = 64, OP_32 and OP_IMM_32 are also supported; their results are computed on the low 32 bits and sign-extended to XLEN.
REQ-021 Arithmetic is modulo 2^XLEN; immediates are sign-extended to XLEN.
REQ-022 Shift amount is rs2/shamt[log2(XLEN)-1:0], and [4:0] for word ops.
REQ-023 SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
REQ-024 SUB/SRA/SRAI are selected by funct7 = 0100000; any other nonzero funct7 on OP is illegal.
REQ-025 Non-control instructions set pc = pc+4.
REQ-026 A taken branch sets pc = pc+immB; a not-taken branch sets pc = pc+4.
REQ-027 JAL writes rd = pc+4 and sets pc = pc+immJ.
REQ-028 JALR sets pc = (rs1+immI) & ~1 and writes rd = old pc+4; the write uses the rs1 value read before writeback when rd == rs1.
REQ-029 PC arithmetic wraps modulo 2^XLEN.
REQ-030 x0 reads as 0 and writes to it are discarded.
REQ-031 Illegal conditions: an unsupported opcode/funct; an rs1, rs2 or rd index >= NREGS; a jump or taken-branch target with bit 1 set.
REQ-032 Illegal response: no register write, pc unchanged, and done and illegal both pulse at the normal WB timing.

Reset
REQ-033 While reset is high at an edge: state = IDLE, all registers = 0, pc = RESET_PC, done = 0 and illegal = 0.
REQ-034 Reset has priority over all other activity, including a capture edge.
REQ-035 Reset during DECODE/EXEC/WB aborts the instruction: no write, no done pulse, and ready = 1 in the first cycle after reset deasserts.

Verification
REQ-036 Scenario: ADDI x1,x0,10; ADDI x2,x0,-4; ADD x3,x1,x2; SUB x4,x1,x2 -> x1=10, x2=-4, x3=6, x4=14, pc=16, with done each time in the 4th cycle after capture.
REQ-037 Scenario: x2=-4, x7=2; SLL, SRL and SRA into x10/x11/x12 -> x10=-16, x11=0x3FFFFFFF, x12=-1; SLTU x6,x0,x2 -> x6=1.
REQ-038 Scenario: BEQ x0,x0,+8 at pc=0 -> pc=8; BNE x0,x0,+8 -> pc=12; JAL x1,-12 -> x1=16, pc=0; BEQ x0,x0,+6 -> illegal=1, pc=0.
REQ-039 Scenario: ADDI x0,x0,5 -> x0 stays 0; with NREGS=16, ADDI x20,x0,1 -> illegal=1 and no register changes.
REQ-040 Scenario: reset asserted in EXEC of ADDI x1,x0,7 -> x1=0, no done pulse, pc=RESET_PC, and ready=1 in the cycle after release.
REQ-041 Scenario: run held high over 3 commands -> done pulses exactly 4 cycles apart; command changes while busy do not alter results; with XLEN=64, ADDIW x1,x0,-1 -> x1=0xFFFFFFFFFFFFFFFF.
